bin2bcd_iter: RTL and testbench

Parametrised, handshaked sequential binary-to-BCD converter (double-dabble), one adjust+shift step per clock. Replaces the fixed 30-bit/9-digit two-phase converter in the display and measurement paths: width and digit count are parameters, conversions are started explicitly, and completion is flagged. It sits between binary counters/accumulators and the seven-segment and UART digit formatters.

---
 rtl/bin2bcd_pkg.sv | 31 +++
 rtl/bcd_digit_adj.sv | 13 +
 rtl/bin2bcd_iter.sv | 124 ++++++++++++
 tb/tb_bin2bcd_iter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared constants, FSM state type and parameter-check helper for the
// iterative double-dabble binary-to-BCD converter.
package bin2bcd_pkg;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] ADJ_THRESH  = 4'd5;
  localparam logic [3:0] ADJ_ADD     = 4'd3;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Smallest digit count d with 10^d > 2^width - 1 (valid for width <= 120).
  function automatic int min_digits(input int width);
    logic [127:0] max_val;
    logic [127:0] pow10;
    int           d;
    max_val = (128'd1 << width) - 128'd1;
    pow10   = 128'd1;
    d       = 0;
    for (int i = 0; i < 39; i++) begin
      if (pow10 <= max_val) begin
        pow10 = pow10 * 128'd10;
        d     = d + 1;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Combinational double-dabble correction cell for one BCD digit:
// adds 3 when the digit is 5 or more, 4-bit wraparound, no carry out.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] adj
);

  // Add-3 correction so the following left shift carries cleanly into the next digit
  assign adj = (digit >= ADJ_THRESH) ? (digit + ADJ_ADD) : digit;

endmodule

// File: rtl/bin2bcd_iter.sv
// Handshaked iterative binary-to-BCD converter, one adjust+shift step per clock.
// Optional feature macro: BIN2BCD_ITER_SIGNED_EN -- treat data as two's
// complement, convert its magnitude and report the sign on sign_out.
module bin2bcd_iter
  import bin2bcd_pkg::*;
#(
  parameter int DATA_W = 30,
  parameter int DIGITS = 10
)
(
  input  logic                            sys_clk,
  input  logic                            sys_rst_n,
  input  logic                            start,
  input  logic [DATA_W-1:0]               data,
  output logic                            busy,
  output logic                            done,
  output logic [BCD_DIGIT_W*DIGITS-1:0]   bcd_data,
  output logic                            sign_out
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int SR_W  = BCD_W + DATA_W;
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

`ifdef BIN2BCD_ITER_SIGNED_EN
  // Largest magnitude is 2^(DATA_W-1), which needs min_digits(DATA_W-1) digits
  localparam int REQ_DIGITS = min_digits(DATA_W - 1);
`else
  localparam int REQ_DIGITS = min_digits(DATA_W);
`endif

  if (DATA_W < 2 || DIGITS < REQ_DIGITS) begin : g_param_check
    $fatal(1, "bin2bcd_iter: DATA_W=%0d needs DIGITS >= %0d (got %0d)",
           DATA_W, REQ_DIGITS, DIGITS);
  end

  state_t            state_reg;
  logic [SR_W-1:0]   sr_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              busy_reg;
  logic              done_reg;
  logic [BCD_W-1:0]  bcd_data_reg;

  logic [DATA_W-1:0] load_mag;
  logic [BCD_W-1:0]  adj_bcd;
  logic [SR_W-1:0]   sr_next;

`ifdef BIN2BCD_ITER_SIGNED_EN
  logic              sign_pend_reg;
  logic              sign_out_reg;

  // Two's complement magnitude; -2^(DATA_W-1) maps to 2^(DATA_W-1) unsigned
  assign load_mag = data[DATA_W-1] ? (-data) : data;
  assign sign_out = sign_out_reg;
`else
  assign load_mag = data;
  assign sign_out = 1'b0;
`endif

  // One correction cell per BCD digit of the shift register's upper field
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    bcd_digit_adj u_adj (
      .digit (sr_reg[DATA_W + BCD_DIGIT_W*gi +: BCD_DIGIT_W]),
      .adj   (adj_bcd[BCD_DIGIT_W*gi +: BCD_DIGIT_W])
    );
  end

  // Adjusted BCD field plus untouched binary field, shifted left with zero fill
  assign sr_next = {adj_bcd, sr_reg[DATA_W-1:0]} << 1;

  // Conversion FSM: load on accepted start, step DATA_W times, publish result
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg     <= IDLE;
      sr_reg        <= '0;
      cnt_reg       <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      bcd_data_reg  <= '0;
`ifdef BIN2BCD_ITER_SIGNED_EN
      sign_pend_reg <= 1'b0;
      sign_out_reg  <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            sr_reg        <= {{BCD_W{1'b0}}, load_mag};
            cnt_reg       <= '0;
            busy_reg      <= 1'b1;
`ifdef BIN2BCD_ITER_SIGNED_EN
            sign_pend_reg <= data[DATA_W-1];
`endif
            state_reg     <= SHIFT;
          end
        end
        SHIFT: begin
          sr_reg  <= sr_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_CNT) begin
            bcd_data_reg <= sr_next[SR_W-1:DATA_W];
`ifdef BIN2BCD_ITER_SIGNED_EN
            sign_out_reg <= sign_pend_reg;
`endif
            done_reg     <= 1'b1;
            busy_reg     <= 1'b0;
            state_reg    <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign bcd_data = bcd_data_reg;

endmodule

// File: tb/tb_bin2bcd_iter.sv
// Self-checking bench for bin2bcd_iter: randomized and directed conversions
// compared against a decimal-arithmetic reference model.
module tb_bin2bcd_iter;

`ifdef BIN2BCD_ITER_SIGNED_EN
  localparam int DW  = 8;
  localparam int DG  = 3;
  localparam bit SGN = 1'b1;
`else
  localparam int DW  = 30;
  localparam int DG  = 10;
  localparam bit SGN = 1'b0;
`endif

  logic            sys_clk;
  logic            sys_rst_n;
  logic            start;
  logic [DW-1:0]   data;
  logic            busy;
  logic            done;
  logic [4*DG-1:0] bcd_data;
  logic            sign_out;

  int n_checks = 0;
  int n_fail   = 0;

  bin2bcd_iter #(.DATA_W(DW), .DIGITS(DG)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (start),
    .data      (data),
    .busy      (busy),
    .done      (done),
    .bcd_data  (bcd_data),
    .sign_out  (sign_out)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic longint ref_mag(input logic [DW-1:0] v);
    longint x;
    x = longint'(v);
    if (SGN && v[DW-1]) x = (longint'(1) <<< DW) - x;
    return x;
  endfunction

  function automatic logic ref_sign(input logic [DW-1:0] v);
    return SGN ? v[DW-1] : 1'b0;
  endfunction

  function automatic logic [4*DG-1:0] ref_bcd(input logic [DW-1:0] v);
    logic [4*DG-1:0] r;
    longint          m;
    m = ref_mag(v);
    r = '0;
    for (int i = 0; i < DG; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  // Stimulus driver only: starts one conversion and collects what happened.
  // Called and returned at a falling edge; c counts rising edges since acceptance.
  task automatic do_conv(input logic [DW-1:0] v, output logic [4*DG-1:0] got,
                         output logic sgn, output int lat, output int busy_bad,
                         output logic busy_at_done);
    data = v;
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    lat = -1; busy_bad = 0; busy_at_done = 1'b0; got = '0; sgn = 1'b0;
    for (int c = 0; c <= DW + 20; c++) begin
      data = DW'($urandom);
      if (done) begin
        lat = c; got = bcd_data; sgn = sign_out; busy_at_done = busy;
        break;
      end
      if (!busy) busy_bad++;
      @(negedge sys_clk);
    end
    $display("conv data=%0h -> bcd=%0h sign=%0b latency=%0d", v, got, sgn, lat);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    sys_rst_n = 1'b0; start = 1'b0; data = '0;
    repeat (3) @(negedge sys_clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%0b exp=0", done); end
    n_checks++; if (bcd_data !== '0) begin n_fail++; $display("FAIL reset_bcd got=%0h exp=0", bcd_data); end
    n_checks++; if (sign_out !== 1'b0) begin n_fail++; $display("FAIL reset_sign got=%0b exp=0", sign_out); end
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset busy=%0b done=%0b exp=0/0", busy, done); end
    $display("reset applied and released");
  endtask

  task automatic test_zero;
    logic [4*DG-1:0] got; logic sgn; int lat; int bb; logic bd;
    do_conv('0, got, sgn, lat, bb, bd);
    n_checks++; if (lat !== DW) begin n_fail++; $display("FAIL zero_latency got=%0d exp=%0d", lat, DW); end
    n_checks++; if (got !== '0) begin n_fail++; $display("FAIL zero_bcd got=%0h exp=0", got); end
    n_checks++; if (bb !== 0) begin n_fail++; $display("FAIL zero_busy_low_cycles got=%0d exp=0", bb); end
    n_checks++; if (bd !== 1'b0) begin n_fail++; $display("FAIL zero_busy_with_done got=%0b exp=0", bd); end
  endtask

  task automatic test_directed;
    logic [DW-1:0] vals[3];
    logic [4*DG-1:0] got; logic sgn; int lat; int bb; logic bd;
    logic [DW-1:0] all_ones;
    all_ones = '1;
    if (SGN) begin
      vals[0] = all_ones; vals[1] = DW'(1) << (DW - 1); vals[2] = all_ones >> 1;
    end else begin
      vals[0] = all_ones; vals[1] = DW'(123456789 % (longint'(1) <<< DW)); vals[2] = DW'(1);
    end
    foreach (vals[i]) begin
      do_conv(vals[i], got, sgn, lat, bb, bd);
      n_checks++; if (got !== ref_bcd(vals[i])) begin n_fail++; $display("FAIL directed_bcd data=%0h got=%0h exp=%0h", vals[i], got, ref_bcd(vals[i])); end
      n_checks++; if (sgn !== ref_sign(vals[i])) begin n_fail++; $display("FAIL directed_sign data=%0h got=%0b exp=%0b", vals[i], sgn, ref_sign(vals[i])); end
      n_checks++; if (lat !== DW) begin n_fail++; $display("FAIL directed_latency got=%0d exp=%0d", lat, DW); end
    end
  endtask

  task automatic test_random;
    logic [DW-1:0] v;
    logic [4*DG-1:0] got; logic sgn; int lat; int bb; logic bd;
    for (int i = 0; i < 12; i++) begin
      v = (i % 3 == 0) ? DW'($urandom_range(0, 99)) : DW'($urandom);
      do_conv(v, got, sgn, lat, bb, bd);
      n_checks++; if (got !== ref_bcd(v) || sgn !== ref_sign(v)) begin n_fail++; $display("FAIL random_result data=%0h got=%0h/%0b exp=%0h/%0b", v, got, sgn, ref_bcd(v), ref_sign(v)); end
      n_checks++; if (lat !== DW || bb !== 0 || bd !== 1'b0) begin n_fail++; $display("FAIL random_timing lat=%0d busy_gaps=%0d busy_at_done=%0b exp=%0d/0/0", lat, bb, bd, DW); end
    end
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] vals[3];
    int cyc, last, ndone;
    vals[0] = DW'(9); vals[1] = DW'(10); vals[2] = DW'(99);
    data = vals[0]; start = 1'b1;
    cyc = -1; last = 0; ndone = 0;
    while (ndone < 3 && cyc < 4 * (DW + 1) + 10) begin
      @(negedge sys_clk);
      cyc++;
      if (done) begin
        $display("b2b done #%0d at cycle %0d bcd=%0h", ndone, cyc, bcd_data);
        n_checks++; if (bcd_data !== ref_bcd(vals[ndone])) begin n_fail++; $display("FAIL b2b_bcd idx=%0d got=%0h exp=%0h", ndone, bcd_data, ref_bcd(vals[ndone])); end
        if (ndone == 0) begin
          n_checks++; if (cyc !== DW) begin n_fail++; $display("FAIL b2b_first_latency got=%0d exp=%0d", cyc, DW); end
        end else begin
          n_checks++; if (cyc - last !== DW + 1) begin n_fail++; $display("FAIL b2b_interval got=%0d exp=%0d", cyc - last, DW + 1); end
        end
        last = cyc;
        ndone++;
        if (ndone < 3) data = vals[ndone];
        else start = 1'b0;
      end
    end
    start = 1'b0;
    n_checks++; if (ndone !== 3) begin n_fail++; $display("FAIL b2b_done_count got=%0d exp=3", ndone); end
    @(negedge sys_clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_after got=%0b exp=0", busy); end
  endtask

  task automatic test_ignored_start;
    logic [DW-1:0] v1, v2;
    logic [4*DG-1:0] got;
    int ndone, lat;
    v1 = DW'($urandom); v2 = ~v1;
    data = v1; start = 1'b1;
    @(negedge sys_clk);
    ndone = 0; lat = -1; got = '0;
    for (int c = 0; c < 2 * DW + 10; c++) begin
      start = (c == 5);
      data = (c == 5) ? v2 : DW'($urandom);
      if (done) begin
        ndone++;
        if (ndone == 1) begin lat = c; got = bcd_data; end
      end
      @(negedge sys_clk);
    end
    start = 1'b0;
    $display("ignored-start conv data=%0h -> bcd=%0h latency=%0d dones=%0d", v1, got, lat, ndone);
    n_checks++; if (ndone !== 1) begin n_fail++; $display("FAIL ignore_done_count got=%0d exp=1", ndone); end
    n_checks++; if (got !== ref_bcd(v1)) begin n_fail++; $display("FAIL ignore_bcd got=%0h exp=%0h", got, ref_bcd(v1)); end
    n_checks++; if (lat !== DW) begin n_fail++; $display("FAIL ignore_latency got=%0d exp=%0d", lat, DW); end
  endtask

  task automatic test_reset_mid;
    logic [DW-1:0] v;
    logic [4*DG-1:0] got; logic sgn; int lat; int bb; logic bd;
    int ndone;
    v = '1;
    do_conv(v, got, sgn, lat, bb, bd);  // leaves a nonzero result on bcd_data
    data = DW'(v - 1'b1); start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    for (int c = 0; c < DW / 2; c++) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midreset_ctrl busy=%0b done=%0b exp=0/0", busy, done); end
    n_checks++; if (bcd_data !== '0) begin n_fail++; $display("FAIL midreset_bcd got=%0h exp=0", bcd_data); end
    n_checks++; if (sign_out !== 1'b0) begin n_fail++; $display("FAIL midreset_sign got=%0b exp=0", sign_out); end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < DW + 5; c++) begin
      @(negedge sys_clk);
      if (done) ndone++;
    end
    $display("reset mid-conversion, dones after release=%0d", ndone);
    n_checks++; if (ndone !== 0) begin n_fail++; $display("FAIL midreset_no_done got=%0d exp=0", ndone); end
    v = DW'($urandom);
    do_conv(v, got, sgn, lat, bb, bd);
    n_checks++; if (got !== ref_bcd(v) || lat !== DW) begin n_fail++; $display("FAIL post_reset_conv got=%0h lat=%0d exp=%0h lat=%0d", got, lat, ref_bcd(v), DW); end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_directed();
    test_random();
    test_back_to_back();
    test_ignored_start();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
